// File: rtl/jtframe_romload.sv
// HPS byte stream to SDRAM programming writes.
// Bytes land in a small FIFO so the HPS never stalls; a three-state
// sequencer turns each entry into one masked write request and keeps
// dwnld_busy asserted until the queue drains and a settle period expires.
module jtframe_romload #(
  parameter int AW          = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter bit SWAP_BYTES  = 1'b0
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  input  logic        prog_rdy,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        dwnld_busy,
  output logic        fifo_ovf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [15:0] HOLD = HOLD_CYCLES[15:0];

  typedef struct packed {
    logic [20:0] addr;
    logic        lane;
    logic [7:0]  data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;

  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  state_t      state_q;
  logic [21:0] prog_addr_q;
  logic [7:0]  prog_data_q;
  logic [1:0]  prog_mask_q;
  logic        prog_we_q;
  logic        busy_q, ovf_q, dl_q;
  logic [15:0] hold_q;

  logic   empty, full, push_req, push, pop, dl_rise, hold_load;
  entry_t head;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_req  = ioctl_wr & downloading;
  assign pop       = (state_q == WRITE) & prog_rdy;
  // A pop in the same cycle frees the slot, so a push at full still fits.
  assign push      = push_req & (~full | pop);
  assign dl_rise   = downloading & ~dl_q;
  assign hold_load = downloading | ~empty | (state_q != IDLE);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk_rom) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= '{ioctl_addr[21:1], ioctl_addr[0] ^ SWAP_BYTES, ioctl_data};
  end

  // FIFO pointers and sticky overflow flag (cleared by a new download).
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req & full & ~pop) ovf_q <= 1'b1;
      else if (dl_rise)           ovf_q <= 1'b0;
    end
  end

  // Write sequencer: load head, hold request until acked, force one idle cycle.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      prog_mask_q <= '0;
      prog_we_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          prog_we_q <= 1'b0;
          if (!empty) begin
            prog_addr_q <= {1'b0, head.addr};
            prog_data_q <= head.data;
            prog_mask_q <= head.lane ? 2'b01 : 2'b10;
            prog_we_q   <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (prog_rdy) begin
            prog_we_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          prog_we_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          prog_we_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  // Busy: set on download start, released when the settle counter runs out.
  always_ff @(posedge clk_rom or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (hold_load)           hold_q <= HOLD;
      else if (hold_q != '0)   hold_q <= hold_q - 16'd1;
      if (dl_rise)                           busy_q <= 1'b1;
      else if (!hold_load && hold_q == 16'd1) busy_q <= 1'b0;
    end
  end

  assign prog_addr  = prog_addr_q;
  assign prog_data  = prog_data_q;
  assign prog_mask  = prog_mask_q;
  assign prog_we    = prog_we_q;
  assign dwnld_busy = busy_q;
  assign fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_jtframe_romload.sv
// Scoreboard bench for jtframe_romload: a byte-level occupancy model decides
// which strobes are accepted and queues the expected SDRAM writes; a monitor
// plays the SDRAM controller and checks each write as it is acknowledged.
module tb_jtframe_romload;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int HOLD  = 16;

  logic        clk_rom = 1'b0;
  logic        rst_n, downloading, ioctl_wr, prog_rdy;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we, dwnld_busy, fifo_ovf;

  // second instance with swapped lanes, acknowledged by hand
  logic        dl1, wr1, rdy1;
  logic [21:0] addr1, prog_addr1;
  logic [7:0]  data1, prog_data1;
  logic [1:0]  prog_mask1;
  logic        prog_we1, busy1, ovf1;

  jtframe_romload #(.AW(AW), .HOLD_CYCLES(HOLD), .SWAP_BYTES(1'b0)) dut (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_rdy(prog_rdy), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_we(prog_we), .dwnld_busy(dwnld_busy),
    .fifo_ovf(fifo_ovf));

  jtframe_romload #(.AW(AW), .HOLD_CYCLES(HOLD), .SWAP_BYTES(1'b1)) dut_swap (
    .clk_rom(clk_rom), .rst_n(rst_n), .downloading(dl1),
    .ioctl_addr(addr1), .ioctl_data(data1), .ioctl_wr(wr1),
    .prog_rdy(rdy1), .prog_addr(prog_addr1), .prog_data(prog_data1),
    .prog_mask(prog_mask1), .prog_we(prog_we1), .dwnld_busy(busy1),
    .fifo_ovf(ovf1));

  initial forever #5 clk_rom = ~clk_rom;

  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   ntests = 0, nfail = 0;
  int   occ = 0, rdy_dly = 2, nwr = 0;
  logic exp_ovf = 1'b0;
  logic busy_watch = 1'b0, busy_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO reduced to an occupancy count plus expected-write queue.
  initial begin
    logic dl_prev;
    dl_prev = 1'b0;
    forever begin
      @(posedge clk_rom or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        occ = 0; exp_ovf = 1'b0; dl_prev = 1'b0;
      end else begin
        if (downloading && !dl_prev) exp_ovf = 1'b0;
        if (ioctl_wr && downloading) begin
          if (occ < DEPTH || prog_rdy) begin
            exp_q.push_back('{{1'b0, ioctl_addr[21:1]}, ioctl_data,
                              ioctl_addr[0] ? 2'b01 : 2'b10});
            occ++;
          end else exp_ovf = 1'b1;
        end
        if (prog_rdy) occ--;
        dl_prev = downloading;
      end
    end
  end

  // Monitor / SDRAM responder: acks each request after rdy_dly cycles and
  // checks it against the scoreboard head at that moment.
  initial begin
    int   wcnt;
    logic we_prev, rdy_prev;
    logic [31:0] last;
    exp_t e;
    wcnt = 0; we_prev = 1'b0; rdy_prev = 1'b0; last = '0;
    prog_rdy = 1'b0;
    forever begin
      @(negedge clk_rom);
      if (!rst_n) begin
        prog_rdy = 1'b0; wcnt = 0; we_prev = 1'b0; rdy_prev = 1'b0;
      end else begin
        chk("fifo_ovf", 32'(fifo_ovf), 32'(exp_ovf));
        if (busy_watch && !dwnld_busy) busy_drop = 1'b1;
        if (prog_we && we_prev) begin
          chk("gap_after_ack", 32'(rdy_prev), 32'd0);
          chk("req_stable", {prog_addr, prog_data, prog_mask}, last);
        end
        last = {prog_addr, prog_data, prog_mask};
        rdy_prev = prog_rdy;
        prog_rdy = 1'b0;
        if (prog_we) begin
          if (wcnt >= rdy_dly) begin
            if (exp_q.size() == 0) chk("spurious_write", 32'(prog_we), 32'd0);
            else begin
              e = exp_q.pop_front();
              chk("wr_addr", 32'(prog_addr), 32'(e.addr));
              chk("wr_data", 32'(prog_data), 32'(e.data));
              chk("wr_mask", 32'(prog_mask), 32'(e.mask));
            end
            nwr++;
            prog_rdy = 1'b1;
            wcnt = 0;
          end else wcnt++;
        end else wcnt = 0;
        we_prev = prog_we;
      end
    end
  end

  task automatic strobe(input logic [21:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk_rom);
    ioctl_wr = 1'b0;
  endtask

  // Returns on the first cycle with nothing queued and no request pending.
  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || prog_we) && t < budget) begin
      @(negedge clk_rom); t++;
    end
    chk("drain_in_time", 32'(t < budget), 32'd1);
  endtask

  initial begin
    int n, nwr0, nb, gap;
    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    dl1 = 1'b0; wr1 = 1'b0; rdy1 = 1'b0; addr1 = '0; data1 = '0;
    repeat (3) @(negedge clk_rom);
    chk("rst_we",   32'(prog_we), 0);
    chk("rst_busy", 32'(dwnld_busy), 0);
    chk("rst_ovf",  32'(fifo_ovf), 0);
    chk("rst_addr", 32'(prog_addr), 0);
    chk("rst_mask", 32'(prog_mask), 0);
    rst_n = 1'b1;
    @(negedge clk_rom);

    // single byte, latency and hold-until-ack
    downloading = 1'b1; rdy_dly = 3;
    @(negedge clk_rom);
    chk("busy_on_start", 32'(dwnld_busy), 1);
    ioctl_addr = 22'h000005; ioctl_data = 8'hA5; ioctl_wr = 1'b1;
    @(negedge clk_rom);
    ioctl_wr = 1'b0;
    chk("lat_we_early", 32'(prog_we), 0);
    @(negedge clk_rom);
    chk("lat_we", 32'(prog_we), 1);
    chk("single_addr", 32'(prog_addr), 32'h2);
    chk("single_data", 32'(prog_data), 32'hA5);
    chk("single_mask", 32'(prog_mask), 32'h1);
    n = 0;
    while (prog_we && n < 50) begin n++; @(negedge clk_rom); end
    chk("we_high_cycles", 32'(n), 32'(rdy_dly + 1));
    @(negedge clk_rom);

    // back-to-back burst overflows the 4-entry FIFO
    rdy_dly = 4;
    for (int i = 0; i < 6; i++) strobe(22'(i), 8'($urandom));
    wait_drain(200);
    chk("burst_ovf", 32'(fifo_ovf), 1);

    // re-download during the hold: busy stays up, overflow clears
    rdy_dly = 6;
    busy_watch = 1'b1; busy_drop = 1'b0;
    strobe(22'h100, 8'h11); strobe(22'h101, 8'h22);
    downloading = 1'b0;
    wait_drain(200);
    repeat (6) @(negedge clk_rom);
    downloading = 1'b1;
    repeat (3) @(negedge clk_rom);
    chk("redl_ovf_clear", 32'(fifo_ovf), 0);
    chk("redl_busy_continuous", 32'(busy_drop), 0);

    // busy hold after drain: GAP cycle plus HOLD settle cycles
    strobe(22'h200, 8'h31); strobe(22'h201, 8'h32); strobe(22'h202, 8'h33);
    downloading = 1'b0;
    wait_drain(300);
    chk("hold_busy_until_drain", 32'(busy_drop), 0);
    busy_watch = 1'b0;
    n = 0;
    while (dwnld_busy && n < 100) begin n++; @(negedge clk_rom); end
    chk("hold_cycles", 32'(n), 32'(HOLD + 1));
    repeat (3) @(negedge clk_rom);
    chk("busy_stays_low", 32'(dwnld_busy), 0);

    // paced 256-byte load never overflows
    downloading = 1'b1; rdy_dly = 2;
    @(negedge clk_rom);
    nwr0 = nwr;
    for (int i = 0; i < 256; i++) begin
      strobe(22'(i), 8'($urandom));
      repeat (7) @(negedge clk_rom);
    end
    wait_drain(200);
    chk("paced_ovf", 32'(fifo_ovf), 0);
    chk("paced_count", 32'(nwr - nwr0), 256);

    // random segments: addresses, data, ack delay, spacing, ignored strobes
    for (int s = 0; s < 6; s++) begin
      rdy_dly = $urandom_range(0, 6);
      nb = $urandom_range(10, 40);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          downloading = 1'b0;
          strobe(22'($urandom), 8'($urandom));
          downloading = 1'b1;
        end else strobe(22'($urandom), 8'($urandom));
        gap = $urandom_range(0, 4);
        repeat (gap) @(negedge clk_rom);
      end
      wait_drain(500);
    end

    // swapped lanes: even address goes to the high byte
    dl1 = 1'b1;
    @(negedge clk_rom);
    addr1 = 22'h000010; data1 = 8'h3C; wr1 = 1'b1;
    @(negedge clk_rom);
    wr1 = 1'b0;
    @(negedge clk_rom);
    chk("swap_we",   32'(prog_we1), 1);
    chk("swap_addr", 32'(prog_addr1), 32'h8);
    chk("swap_mask", 32'(prog_mask1), 32'h1);
    chk("swap_data", 32'(prog_data1), 32'h3C);

    // async reset mid-write with overflow set
    rdy_dly = 1000;
    for (int i = 0; i < 8; i++) strobe(22'(i + 'h40), 8'($urandom));
    chk("pre_rst_we",  32'(prog_we), 1);
    chk("pre_rst_ovf", 32'(fifo_ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",     32'(prog_we), 0);
    chk("arst_busy",   32'(dwnld_busy), 0);
    chk("arst_ovf",    32'(fifo_ovf), 0);
    chk("arst_swp_we", 32'(prog_we1), 0);
    chk("arst_swp_busy", 32'(busy1), 0);
    repeat (2) @(negedge clk_rom);
    rdy_dly = 2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk_rom);
    chk("fifo_lost_we", 32'(prog_we), 0);
    chk("fifo_lost_swp_we", 32'(prog_we1), 0);

    // swapped lanes after reset: odd address goes to the low byte
    addr1 = 22'h000021; data1 = 8'h5A; wr1 = 1'b1;
    @(negedge clk_rom);
    wr1 = 1'b0;
    @(negedge clk_rom);
    chk("swap_odd_mask", 32'(prog_mask1), 32'h2);
    chk("swap_odd_addr", 32'(prog_addr1), 32'h10);
    rdy1 = 1'b1;
    @(negedge clk_rom);
    rdy1 = 1'b0;
    chk("swap_ack_we", 32'(prog_we1), 0);

    strobe(22'h3FFFFF, 8'hEE);
    wait_drain(100);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
